// File: rtl/imem_pkg.sv
// imem_pkg: shared fault codes, NOP constant and response payload for instruction_fetch_mem
package imem_pkg;
   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_RANGE    = 2'b10;
   localparam logic [31:0] NOP = 32'h0000_0013;
   typedef struct packed {
      logic [31:0] inst;
      logic [1:0]  fault;
   } rsp_t;
endpackage

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: ordered response buffer with occupancy counter and modulo-DEPTH pointers
// Ports: clk, rst_n (async active-low), flush (clear all entries), push/din (enqueue),
//        pop (dequeue head), dout (head entry), count (occupancy).
module imem_rsp_fifo #(
   parameter int W     = 34,
   parameter int DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic                           push,
   input  logic [W-1:0]                   din,
   input  logic                           pop,
   output logic [W-1:0]                   dout,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   // DEPTH need not be a power of two, so wrap explicitly
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop) rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push && !flush) store[wr_ptr] <= din;
   end
   assign dout = store[rd_ptr];
endmodule

// File: rtl/instruction_fetch_mem.sv
// instruction_fetch_mem: byte-addressed instruction memory with ordered, back-pressured fetch responses
module instruction_fetch_mem
   import imem_pkg::*;
#(
   parameter int    ADDR_W      = 64,
   parameter int    DEPTH_BYTES = 256,
   parameter string INIT_FILE   = "",
   parameter int    RSP_DEPTH   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_inst,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [1:0]        rsp_fault,
   input  logic              flush
`ifdef IMEM_WRITE_PORT_EN
   ,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_data,
   input  logic [3:0]        wr_be
`endif
);
   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int CW = $clog2(RSP_DEPTH+1);
   localparam int FW = ADDR_W + $bits(rsp_t);
   logic [7:0]        mem [DEPTH_BYTES];
   logic [AW-1:0]     a;
   rsp_t              rsp, head;
   logic [ADDR_W-1:0] head_addr;
   logic [CW-1:0]     count;
   logic              live, pop, push;
   initial begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] = 8'h00;
   end
`ifdef IMEM_WRITE_PORT_EN
   logic          wr_ok;
   logic [AW-1:0] wa;
   assign wr_ok = wr_en && (wr_addr[1:0] == 2'b00) && (wr_addr <= ADDR_W'(DEPTH_BYTES-4));
   assign wa    = {wr_addr[AW-1:2], 2'b00};
   always_ff @(posedge clk) begin
      if (wr_ok)
         for (int b = 0; b < 4; b++)
            if (wr_be[b]) mem[wa + AW'(b)] <= wr_data[8*b +: 8];
   end
`endif
   assign a = req_addr[AW-1:0];
   always_comb begin
      rsp.fault = (req_addr[1:0] != 2'b00)               ? FAULT_MISALIGN :
                  (req_addr > ADDR_W'(DEPTH_BYTES-4))    ? FAULT_RANGE    : FAULT_NONE;
      rsp.inst  = (rsp.fault != FAULT_NONE) ? NOP :
                  {mem[a + AW'(3)], mem[a + AW'(2)], mem[a + AW'(1)], mem[a]};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) live <= 1'b0;
      else live <= 1'b1;
   end
   assign rsp_valid = (count != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign req_ready = live && !flush && ((count < CW'(RSP_DEPTH)) || pop);
   assign push      = req_valid && req_ready;
   imem_rsp_fifo #(.W(FW), .DEPTH(RSP_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .din   ({req_addr, rsp}),
      .pop   (pop),
      .dout  ({head_addr, head}),
      .count (count)
   );
   assign rsp_inst  = rsp_valid ? head.inst  : '0;
   assign rsp_fault = rsp_valid ? head.fault : '0;
   assign rsp_addr  = rsp_valid ? head_addr  : '0;
endmodule
